// File: rtl/matmul_host_seq.sv
// Host sequencer: kicks the matrix-multiply engine, then streams the result SRAM out via a 2-deep FIFO.
// Optional feature macro: RESULT_CHECKSUM_EN adds an XOR checksum output over the streamed words.
module matmul_host_seq #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [15:0]       cmd_count,
  output logic              dut_valid,
  input  logic              dut_ready,
  output logic [ADDR_W-1:0] host__tb__sram_result_read_address,
  input  logic [DATA_W-1:0] tb__host__sram_result_read_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              job_done
`ifdef RESULT_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0] checksum
`endif
);

  typedef enum logic [2:0] {StIdle, StArm, StKick, StBusy, StDrain, StDone} state_e;

  state_e            state_q, state_d;
  logic [15:0]       count_q;
  logic [15:0]       issued_q;
  logic [15:0]       accepted_q;
  logic              inflight_q;
  logic [DATA_W-1:0] fifo_q [2];
  logic              wr_ptr_q;
  logic              rd_ptr_q;
  logic [1:0]        occ_q;

  logic       accept;
  logic       pop;
  logic       issue;
  logic       last_pop;
  logic [2:0] pending;

  always_comb begin
    accept   = (state_q == StIdle) && cmd_valid;
    m_valid  = (occ_q != 2'd0);
    pop      = m_valid && m_ready;
    // Slots already spoken for once this cycle's pop is accounted for.
    pending  = {2'b0, inflight_q} + {1'b0, occ_q} - {2'b0, pop};
    issue    = (state_q == StDrain) && (issued_q < count_q) && (pending < 3'd2);
    last_pop = pop && (accepted_q == count_q - 16'd1);
    m_data   = m_valid ? fifo_q[rd_ptr_q] : '0;
    host__tb__sram_result_read_address = issued_q[ADDR_W-1:0];
  end

  always_comb begin
    state_d   = state_q;
    cmd_ready = 1'b0;
    dut_valid = 1'b0;
    job_done  = 1'b0;
    case (state_q)
      StIdle: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_d = StArm;
      end
      StArm: begin
        if (dut_ready) state_d = StKick;
      end
      StKick: begin
        dut_valid = 1'b1;
        if (!dut_ready) state_d = StBusy;
      end
      StBusy: begin
        if (dut_ready) state_d = (count_q == 16'd0) ? StDone : StDrain;
      end
      StDrain: begin
        if (last_pop) state_d = StDone;
      end
      StDone: begin
        job_done = 1'b1;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      count_q    <= '0;
      issued_q   <= '0;
      accepted_q <= '0;
      inflight_q <= 1'b0;
      fifo_q[0]  <= '0;
      fifo_q[1]  <= '0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      occ_q      <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        count_q    <= cmd_count;
        issued_q   <= '0;
        accepted_q <= '0;
      end else begin
        if (issue) issued_q <= issued_q + 16'd1;
        if (pop) accepted_q <= accepted_q + 16'd1;
      end
      // SRAM returns data one cycle after the address, so the in-flight read lands now.
      inflight_q <= issue;
      if (inflight_q) begin
        fifo_q[wr_ptr_q] <= tb__host__sram_result_read_data;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      occ_q <= occ_q + {1'b0, inflight_q} - {1'b0, pop};
    end
  end

`ifdef RESULT_CHECKSUM_EN
  logic [DATA_W-1:0] checksum_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      checksum_q <= '0;
    end else if (accept) begin
      checksum_q <= '0;
    end else if (pop) begin
      checksum_q <= checksum_q ^ m_data;
    end
  end

  always_comb checksum = checksum_q;
`endif

endmodule

// File: tb/tb_matmul_host_seq.sv
// Directed self-checking bench for matmul_host_seq with engine and result-SRAM models.
// Define RESULT_CHECKSUM_EN to also exercise the checksum output.
module tb_matmul_host_seq;

  logic        clk;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [15:0] cmd_count;
  logic        dut_valid;
  logic        dut_ready;
  logic [11:0] sram_addr;
  logic [31:0] sram_rdata;
  logic        m_valid;
  logic        m_ready;
  logic [31:0] m_data;
  logic        job_done;
`ifdef RESULT_CHECKSUM_EN
  logic [31:0] checksum;
`endif

  matmul_host_seq #(
    .ADDR_W(12),
    .DATA_W(32)
  ) u_dut (
    .clk                                (clk),
    .reset                              (reset),
    .cmd_valid                          (cmd_valid),
    .cmd_ready                          (cmd_ready),
    .cmd_count                          (cmd_count),
    .dut_valid                          (dut_valid),
    .dut_ready                          (dut_ready),
    .host__tb__sram_result_read_address (sram_addr),
    .tb__host__sram_result_read_data    (sram_rdata),
    .m_valid                            (m_valid),
    .m_ready                            (m_ready),
    .m_data                             (m_data),
    .job_done                           (job_done)
`ifdef RESULT_CHECKSUM_EN
    ,
    .checksum                           (checksum)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] mem [0:4095];
  logic        eng_hold = 1'b0;
  int          eng_cnt  = 0;

  // Result SRAM: data for the address seen in cycle t appears in cycle t+1.
  initial begin
    logic [31:0] cap;
    sram_rdata = '0;
    forever begin
      @(negedge clk);
      cap = mem[sram_addr];
      @(posedge clk);
      #1;
      sram_rdata = cap;
    end
  end

  // Engine: drops ready on a kick, raises it again 20 cycles later.
  initial begin
    dut_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (eng_hold) dut_ready = 1'b0;
      else if (eng_cnt > 0) begin
        eng_cnt--;
        if (eng_cnt == 0) dut_ready = 1'b1;
      end else if (!dut_ready) dut_ready = 1'b1;
      else if (dut_valid) begin
        dut_ready = 1'b0;
        eng_cnt   = 20;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  logic [31:0] got[$];
  int          hs_cyc[$];
  int          done_cyc, rise_cyc, first_v_cyc;
  bit          addr_moved;

  task automatic accept(input logic [15:0] cnt);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_count = cnt;
    #1 check("cmd_ready_idle", 32'(cmd_ready), 32'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
    #1 check("cmd_ready_busy", 32'(cmd_ready), 32'd0);
  endtask

  // rmode 0: m_ready always 1; rmode 1: pattern 1,0,0 repeating.
  task automatic run_job(input int rmode, input int stop_after);
    bit          seen_low = 1'b0;
    bit          prev_stall = 1'b0;
    bit          fin = 1'b0;
    logic [31:0] prev_data = '0;
    got.delete();
    hs_cyc.delete();
    done_cyc = -1; rise_cyc = -1; first_v_cyc = -1; addr_moved = 1'b0;
    for (int c = 0; c < 300 && !fin; c++) begin
      @(negedge clk);
      #1;
      m_ready = (rmode == 0) ? 1'b1 : (c % 3 == 0);
      if (!dut_ready) seen_low = 1'b1;
      else if (seen_low && rise_cyc < 0) rise_cyc = c;
      if (sram_addr != 12'd0) addr_moved = 1'b1;
      if (m_valid && first_v_cyc < 0) first_v_cyc = c;
      if (prev_stall) begin
        check("stall_valid", 32'(m_valid), 32'd1);
        check("stall_data", m_data, prev_data);
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      if (m_valid && m_ready) begin
        got.push_back(m_data);
        hs_cyc.push_back(c);
        if (got.size() == stop_after) fin = 1'b1;
      end
      if (job_done) begin
        done_cyc = c;
        fin      = 1'b1;
      end
    end
    if (!fin) check("job_timeout", 32'd0, 32'd1);
    m_ready = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = '0;
    mem[0] = 32'h3F80_0000;
    mem[1] = 32'h4000_0000;
    mem[2] = 32'h4040_0000;
    mem[3] = 32'h4080_0000;
    mem[4] = 32'h40A0_0000;
    mem[5] = 32'h40C0_0000;
    cmd_valid = 1'b0;
    cmd_count = '0;
    m_ready   = 1'b0;
    reset     = 1'b1;

    repeat (3) @(negedge clk);
    #1;
    check("rst_dut_valid", 32'(dut_valid), 32'd0);
    check("rst_m_valid", 32'(m_valid), 32'd0);
    check("rst_job_done", 32'(job_done), 32'd0);
    check("rst_m_data", m_data, 32'd0);
    check("rst_addr", 32'(sram_addr), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    #1 check("rst_cmd_ready", 32'(cmd_ready), 32'd1);

    // Count 4, m_ready held high: back-to-back stream then job_done.
    accept(16'd4);
    run_job(0, 0);
    check("c4_words", 32'(got.size()), 32'd4);
    for (int i = 0; i < 4; i++) check("c4_data", got[i], mem[i]);
    check("c4_first_valid", 32'(first_v_cyc), 32'(rise_cyc + 3));
    for (int i = 1; i < 4; i++) check("c4_back_to_back", 32'(hs_cyc[i]), 32'(hs_cyc[0] + i));
    check("c4_done_lat", 32'(done_cyc), 32'(hs_cyc[3] + 1));

    // Count 6 with back-pressure.
    accept(16'd6);
    run_job(1, 0);
    check("c6_words", 32'(got.size()), 32'd6);
    for (int i = 0; i < 6; i++) check("c6_data", got[i], mem[i]);
    check("c6_done_seen", 32'(done_cyc >= 0), 32'd1);

    // Count 0: no reads, no stream, done right after engine completes.
    accept(16'd0);
    run_job(0, 0);
    check("c0_no_valid", 32'(first_v_cyc), 32'hFFFF_FFFF);
    check("c0_addr_idle", 32'(addr_moved), 32'd0);
    check("c0_done_lat", 32'(done_cyc), 32'(rise_cyc + 1));

    // Engine not ready at accept: must sit in ARM.
    eng_hold = 1'b1;
    @(negedge clk);
    accept(16'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1 check("arm_hold_valid", 32'(dut_valid), 32'd0);
    end
    eng_hold = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1 check("arm_kick_valid", 32'(dut_valid), 32'd1);
    run_job(0, 0);
    check("arm_words", 32'(got.size()), 32'd1);
    check("arm_data", got[0], mem[0]);

    // Reset mid-drain after two words, then a fresh job restarts at address 0.
    accept(16'd5);
    run_job(0, 2);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    #1;
    check("mid_rst_m_valid", 32'(m_valid), 32'd0);
    check("mid_rst_dut_valid", 32'(dut_valid), 32'd0);
    check("mid_rst_job_done", 32'(job_done), 32'd0);
    check("mid_rst_addr", 32'(sram_addr), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    #1;
    check("mid_rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("mid_rst_no_done", 32'(job_done), 32'd0);
    accept(16'd3);
    run_job(0, 0);
    check("restart_words", 32'(got.size()), 32'd3);
    for (int i = 0; i < 3; i++) check("restart_data", got[i], mem[i]);

`ifdef RESULT_CHECKSUM_EN
    mem[0] = 32'h1;
    mem[1] = 32'h2;
    mem[2] = 32'h4;
    accept(16'd3);
    run_job(0, 0);
    #1 check("checksum", checksum, 32'h7);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/matmul_host_seq.md
MATMUL_HOST_SEQ -- requirements
Module: matmul_host_seq

Interface
REQ-001 SHALL have parameter ADDR_W, default 12, the result SRAM address width.
REQ-002 SHALL have parameter DATA_W, default 32, the result word width.
REQ-003 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have ports cmd_valid (input, 1), cmd_ready (output, 1) and cmd_count (input, 16): the job request and its number of result words.
REQ-006 SHALL have ports dut_valid (output, 1) and dut_ready (input, 1): the start/done handshake toward the matrix-multiply engine.
REQ-007 SHALL have ports host__tb__sram_result_read_address (output, ADDR_W) and tb__host__sram_result_read_data (input, DATA_W): the result SRAM read port, data valid 1 cycle after the address.
REQ-008 SHALL have ports m_valid (output, 1), m_ready (input, 1) and m_data (output, DATA_W): the result stream.
REQ-009 SHALL have port job_done, output, 1 bit: a 1-cycle pulse at the end of each job.

Function
REQ-010 SHALL implement the FSM states IDLE, ARM, KICK, BUSY, DRAIN and DONE.
REQ-011 In IDLE, SHALL drive cmd_ready=1 and accept a job when cmd_valid&cmd_ready, latching cmd_count, then go to ARM.
REQ-012 SHALL drive cmd_ready=0 in every state except IDLE.
REQ-013 In ARM, SHALL wait for dut_ready=1 sampled, with dut_valid=0, then go to KICK.
REQ-014 In KICK, SHALL hold dut_valid=1 until dut_ready=0 is sampled, then go to BUSY with dut_valid=0 the next cycle.
REQ-015 In BUSY, SHALL wait for dut_ready=1, then go to DRAIN; if the latched count is 0, SHALL go directly to DONE instead.
REQ-016 In DRAIN, SHALL read result addresses 0..count-1 in ascending order, one read per cycle maximum.
REQ-017 SHALL buffer read data in a 2-entry output FIFO, and SHALL issue a read only when reads in flight + FIFO occupancy - (m_valid&m_ready) < 2.
REQ-018 SHALL hold the read address stable when no read is issued.
REQ-019 SHALL drive m_valid=1 whenever the FIFO is non-empty, with m_data = the FIFO head, in address order.
REQ-020 SHALL accept a word only on m_valid&m_ready, and SHALL keep m_data stable while m_valid=1 and m_ready=0.
REQ-021 With m_ready held at 1, SHALL sustain 1 word per cycle; the first m_valid SHALL occur 2 cycles after entering DRAIN.
REQ-022 SHALL leave DRAIN after the final word (count-th) handshake and enter DONE.
REQ-023 In DONE, SHALL pulse job_done=1 for 1 cycle, then return to IDLE.
REQ-024 SHALL use a 16-bit issued-read counter and a 16-bit accepted-word counter, and SHALL use the lower ADDR_W bits of the issue counter as the read address; counts above 2^ADDR_W wrap the address (caller error, no flag).
REQ-025 SHALL ignore cmd_valid in non-IDLE states; cmd_count is not re-sampled mid-job.
REQ-026 SHALL ignore glitches on dut_ready in ARM/BUSY apart from the sampled level.

Reset
REQ-027 On reset, SHALL clear state to IDLE, clear the FIFO and counters, and cancel any in-flight read.
REQ-028 SHALL hold these output values during and after reset: cmd_ready=1 (after the first non-reset cycle in IDLE), dut_valid=0, m_valid=0, job_done=0, m_data=0, read address=0.
REQ-029 SHALL apply the reset values when reset is asserted mid-job in any state, with no job_done pulse.

Configuration
REQ-030 SHALL use macro RESULT_CHECKSUM_EN to compile the checksum feature in or out.
REQ-031 When RESULT_CHECKSUM_EN is defined, SHALL add output port checksum (DATA_W), cleared on job accept, updated as checksum XOR m_data on each m handshake, and valid/stable from DONE until the next accept.
REQ-032 When RESULT_CHECKSUM_EN is undefined, SHALL omit the port and all associated logic.

Verification
REQ-033 Count=4, engine model raises dut_ready 20 cycles after dut_valid, SRAM[0..3]=0x3F800000,0x40000000,0x40400000,0x40800000, m_ready=1 -> SHALL stream the 4 words on 4 consecutive cycles, then job_done 1 cycle later.
REQ-034 Count=6, m_ready toggled 1,0,0,1,... -> SHALL deliver all 6 words in order, with no duplicates, and m_data held stable on stalls.
REQ-035 Count=0 -> SHALL perform no SRAM reads, never assert m_valid, and pulse job_done after dut_ready returns to 1.
REQ-036 cmd_valid while dut_ready=0 at accept -> SHALL stay in ARM with dut_valid=0 until dut_ready=1, then KICK.
REQ-037 Reset asserted in DRAIN after 2 of 5 words -> SHALL assert m_valid=0, dut_valid=0 and cmd_ready=1 in IDLE; a following job SHALL restart from address 0.
REQ-038 With RESULT_CHECKSUM_EN, words 0x1,0x2,0x4 -> SHALL give checksum=0x7 at job_done.
